// File: rtl/memory_access_pkg.sv
// Shared definitions for the MEM pipeline stage: access-width encodings,
// dump engine states and default geometry.
package mem_pkg;

    localparam int DEFAULT_NBITS     = 32;
    localparam int DEFAULT_MEM_WORDS = 64;
    localparam int DEFAULT_REGS      = 5;
    localparam int WORD_BITS         = 32;

    // Encodings of the i_width control field (2'b10 is treated as a word).
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_SEND = 1'b1
    } dump_state_e;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2
    } acc_size_e;

    // Collapse the raw width field into an access size; unused code 2'b10
    // behaves as a word access.
    function automatic acc_size_e decode_width(input logic [1:0] width);
        acc_size_e size;
        case (width)
            WIDTH_BYTE: size = ACC_BYTE;
            WIDTH_HALF: size = ACC_HALF;
            default:    size = ACC_WORD;
        endcase
        return size;
    endfunction

    // Byte-lane write enable for a little-endian store of the given size.
    function automatic logic [3:0] lane_enable(input acc_size_e size, input logic [1:0] off);
        logic [3:0] en;
        case (size)
            ACC_BYTE: en = 4'b0001 << off;
            ACC_HALF: en = off[1] ? 4'b1100 : 4'b0011;
            default:  en = 4'b1111;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Bundle of the MEM stage pipeline inputs, MEM/WB latch outputs and the
// debug dump handshake. master = driver of the stage (EX side / debug unit),
// slave = the memory_access block itself.
interface memory_access_if #(
    parameter int NBITS = 32,
    parameter int REGS  = 5
) ();
    import mem_pkg::*;

    // pipeline inputs
    logic             i_step;
    logic [NBITS-1:0] i_alu_result;
    logic [NBITS-1:0] i_store_data;
    logic             i_mem_read;
    logic             i_mem_write;
    logic [1:0]       i_width;
    logic             i_unsigned;
    logic             i_reg_write;
    logic             i_mem_to_reg;
    logic [REGS-1:0]  i_rd;

    // MEM/WB latch
    logic [NBITS-1:0] o_wb_mem_data;
    logic [NBITS-1:0] o_wb_alu_result;
    logic [REGS-1:0]  o_wb_rd;
    logic             o_wb_reg_write;
    logic             o_wb_mem_to_reg;
    logic             o_misaligned;

    // debug dump stream
    logic             i_dbg_start;
    logic             i_dbg_ready;
    logic             o_dbg_valid;
    logic [NBITS-1:0] o_dbg_data;
    logic             o_dbg_busy;
    logic             o_dbg_done;

    modport master (
        output i_step, i_alu_result, i_store_data, i_mem_read, i_mem_write,
               i_width, i_unsigned, i_reg_write, i_mem_to_reg, i_rd,
               i_dbg_start, i_dbg_ready,
        input  o_wb_mem_data, o_wb_alu_result, o_wb_rd, o_wb_reg_write,
               o_wb_mem_to_reg, o_misaligned,
               o_dbg_valid, o_dbg_data, o_dbg_busy, o_dbg_done
    );

    modport slave (
        input  i_step, i_alu_result, i_store_data, i_mem_read, i_mem_write,
               i_width, i_unsigned, i_reg_write, i_mem_to_reg, i_rd,
               i_dbg_start, i_dbg_ready,
        output o_wb_mem_data, o_wb_alu_result, o_wb_rd, o_wb_reg_write,
               o_wb_mem_to_reg, o_misaligned,
               o_dbg_valid, o_dbg_data, o_dbg_busy, o_dbg_done
    );

endinterface

// File: rtl/memory_access_data_memory.sv
// Data memory for the MEM stage: MEM_WORDS x 32 bits, stored as four byte
// lanes so each lane has its own write enable. One combinational read port
// serves the pipeline, a second one serves the dump engine. Contents are
// never reset.
module data_memory
    import mem_pkg::*;
#(
    parameter  int MEM_WORDS = DEFAULT_MEM_WORDS,
    localparam int IDXW      = $clog2(MEM_WORDS)
) (
    input  logic                 i_clk,
    input  logic [3:0]           i_we,
    input  logic [IDXW-1:0]      i_addr,
    input  logic [WORD_BITS-1:0] i_wdata,
    output logic [WORD_BITS-1:0] o_rdata,
    input  logic [IDXW-1:0]      i_dump_addr,
    output logic [WORD_BITS-1:0] o_dump_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [MEM_WORDS];

            // Byte-lane write, only when this lane is enabled.
            always_ff @(posedge i_clk) begin
                if (i_we[gi]) begin
                    r_lane[i_addr] <= i_wdata[gi*8 +: 8];
                end
            end

            assign o_rdata[gi*8 +: 8]      = r_lane[i_addr];
            assign o_dump_rdata[gi*8 +: 8] = r_lane[i_dump_addr];
        end
    endgenerate

endmodule

// File: rtl/memory_access.sv
// MEM stage of the MIPS core: byte/half/word loads and stores on a
// little-endian data memory, the MEM/WB pipeline latch, and a debug engine
// that streams the whole memory over a valid/ready handshake.
// Optional feature macro: MEM_MISALIGN_CHECK_EN enables misaligned-access
// detection (write suppression, zeroed load data, sticky o_misaligned).
// Without it, low address bits are ignored for half/word accesses.
module memory_access
    import mem_pkg::*;
#(
    parameter int NBITS     = DEFAULT_NBITS,
    parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter int REGS      = DEFAULT_REGS
) (
    input  logic         i_clk,
    input  logic         i_reset,
    memory_access_if.slave bus
);

    localparam int IDXW = $clog2(MEM_WORDS);

    // registered state
    logic [NBITS-1:0] r_wb_mem_data;
    logic [NBITS-1:0] r_wb_alu_result;
    logic [REGS-1:0]  r_wb_rd;
    logic             r_wb_reg_write;
    logic             r_wb_mem_to_reg;
    logic             r_misaligned;

    dump_state_e      r_dbg_state;
    logic [IDXW-1:0]  r_dbg_index;
    logic             r_dbg_valid;
    logic             r_dbg_busy;
    logic             r_dbg_done;

    // combinational datapath
    logic                 w_step;
    acc_size_e            w_size;
    logic [1:0]           w_off;
    logic                 w_mis;
    logic [IDXW-1:0]      w_idx;
    logic [3:0]           w_we;
    logic [WORD_BITS-1:0] w_wdata;
    logic [WORD_BITS-1:0] w_rdata;
    logic [WORD_BITS-1:0] w_dump_rdata;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [WORD_BITS-1:0] w_load_data;

    // The pipeline freezes while the dump engine owns the memory, so the
    // streamed image is a consistent snapshot.
    assign w_step = bus.i_step & ~r_dbg_busy;
    assign w_size = decode_width(bus.i_width);
    assign w_idx  = bus.i_alu_result[IDXW+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_off = bus.i_alu_result[1:0];

    // Half needs addr[0]==0, word needs addr[1:0]==0.
    always_comb begin
        w_mis = 1'b0;
        case (w_size)
            ACC_HALF: w_mis = w_off[0];
            ACC_WORD: w_mis = (w_off != 2'b00);
            default:  w_mis = 1'b0;
        endcase
    end
`else
    // Force alignment by dropping the low address bits the size ignores.
    always_comb begin
        w_off = bus.i_alu_result[1:0];
        case (w_size)
            ACC_HALF: w_off = {bus.i_alu_result[1], 1'b0};
            ACC_WORD: w_off = 2'b00;
            default:  w_off = bus.i_alu_result[1:0];
        endcase
    end

    assign w_mis = 1'b0;
`endif

    // Replicate store data across lanes; the lane enables pick the target.
    always_comb begin
        w_wdata = bus.i_store_data[WORD_BITS-1:0];
        case (w_size)
            ACC_BYTE: w_wdata = {4{bus.i_store_data[7:0]}};
            ACC_HALF: w_wdata = {2{bus.i_store_data[15:0]}};
            default:  w_wdata = bus.i_store_data[WORD_BITS-1:0];
        endcase
    end

    assign w_we = (w_step & bus.i_mem_write & ~w_mis) ? lane_enable(w_size, w_off) : 4'b0000;

    data_memory #(
        .MEM_WORDS (MEM_WORDS)
    ) u_data_memory (
        .i_clk        (i_clk),
        .i_we         (w_we),
        .i_addr       (w_idx),
        .i_wdata      (w_wdata),
        .o_rdata      (w_rdata),
        .i_dump_addr  (r_dbg_index),
        .o_dump_rdata (w_dump_rdata)
    );

    // Lane extraction and sign/zero extension of the loaded value.
    always_comb begin
        case (w_off)
            2'd0:    w_byte = w_rdata[7:0];
            2'd1:    w_byte = w_rdata[15:8];
            2'd2:    w_byte = w_rdata[23:16];
            default: w_byte = w_rdata[31:24];
        endcase
        w_half = w_off[1] ? w_rdata[31:16] : w_rdata[15:0];

        w_load_data = '0;
        if (bus.i_mem_read && !w_mis) begin
            case (w_size)
                ACC_BYTE: w_load_data = bus.i_unsigned ? {24'h0, w_byte}
                                                       : {{24{w_byte[7]}}, w_byte};
                ACC_HALF: w_load_data = bus.i_unsigned ? {16'h0, w_half}
                                                       : {{16{w_half[15]}}, w_half};
                default:  w_load_data = w_rdata;
            endcase
        end
    end

    // MEM/WB pipeline latch; holds while stalled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wb_mem_data   <= '0;
            r_wb_alu_result <= '0;
            r_wb_rd         <= '0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
        end else if (w_step) begin
            r_wb_mem_data   <= w_load_data;
            r_wb_alu_result <= bus.i_alu_result;
            r_wb_rd         <= bus.i_rd;
            r_wb_reg_write  <= bus.i_reg_write;
            r_wb_mem_to_reg <= bus.i_mem_to_reg;
        end
    end

    // Sticky misaligned flag, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_misaligned <= 1'b0;
        end else if (w_step && (bus.i_mem_read || bus.i_mem_write) && w_mis) begin
            r_misaligned <= 1'b1;
        end
    end

    // Dump engine: walk every word from index 0, one per accepted beat.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dbg_state <= DUMP_IDLE;
            r_dbg_index <= '0;
            r_dbg_valid <= 1'b0;
            r_dbg_busy  <= 1'b0;
            r_dbg_done  <= 1'b0;
        end else begin
            r_dbg_done <= 1'b0;
            case (r_dbg_state)
                DUMP_IDLE: begin
                    if (bus.i_dbg_start) begin
                        r_dbg_state <= DUMP_SEND;
                        r_dbg_index <= '0;
                        r_dbg_valid <= 1'b1;
                        r_dbg_busy  <= 1'b1;
                    end
                end
                DUMP_SEND: begin
                    if (bus.i_dbg_ready) begin
                        if (r_dbg_index == IDXW'(MEM_WORDS - 1)) begin
                            r_dbg_state <= DUMP_IDLE;
                            r_dbg_index <= '0;
                            r_dbg_valid <= 1'b0;
                            r_dbg_busy  <= 1'b0;
                            r_dbg_done  <= 1'b1;
                        end else begin
                            r_dbg_index <= r_dbg_index + 1'b1;
                        end
                    end
                end
                default: begin
                    r_dbg_state <= DUMP_IDLE;
                    r_dbg_valid <= 1'b0;
                    r_dbg_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_wb_mem_data   = r_wb_mem_data;
    assign bus.o_wb_alu_result = r_wb_alu_result;
    assign bus.o_wb_rd         = r_wb_rd;
    assign bus.o_wb_reg_write  = r_wb_reg_write;
    assign bus.o_wb_mem_to_reg = r_wb_mem_to_reg;
    assign bus.o_misaligned    = r_misaligned;
    assign bus.o_dbg_valid     = r_dbg_valid;
    assign bus.o_dbg_data      = w_dump_rdata;
    assign bus.o_dbg_busy      = r_dbg_busy;
    assign bus.o_dbg_done      = r_dbg_done;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: pipeline loads/stores against a
// byte-lane memory model through a scoreboard queue, plus the dump engine.
module tb_memory_access;
    import mem_pkg::*;

    localparam int MW = 64;

    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    memory_access_if #(.NBITS(32), .REGS(5)) bus ();

    memory_access #(.NBITS(32), .MEM_WORDS(MW), .REGS(5)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [31:0] mem_data;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mis;
    } wb_t;

    int          checks = 0;
    int          passed = 0;
    wb_t         sb_q[$];
    logic [31:0] dump_q[$];
    logic [31:0] mdl_mem [MW];
    wb_t         exp_wb;
    logic        exp_mis;

    function automatic logic [31:0] fill_pat(input int i);
        return {8'(i), 8'(8'hFF - i), 8'(i * 3), 8'(i ^ 8'h5A)};
    endfunction

    function automatic wb_t actual_wb();
        wb_t a;
        a.mem_data = bus.o_wb_mem_data;
        a.alu      = bus.o_wb_alu_result;
        a.rd       = bus.o_wb_rd;
        a.rw       = bus.o_wb_reg_write;
        a.m2r      = bus.o_wb_mem_to_reg;
        a.mis      = bus.o_misaligned;
        return a;
    endfunction

    task automatic idle_inputs();
        bus.i_step = 0; bus.i_alu_result = 0; bus.i_store_data = 0;
        bus.i_mem_read = 0; bus.i_mem_write = 0; bus.i_width = 0;
        bus.i_unsigned = 0; bus.i_reg_write = 0; bus.i_mem_to_reg = 0;
        bus.i_rd = 0; bus.i_dbg_start = 0; bus.i_dbg_ready = 0;
    endtask

    // One pipeline transaction: model predicts the latch, DUT is compared
    // one edge later. Called at posedge+1, returns at the next posedge+1.
    task automatic pipe_op(input string tag, input logic step, input logic rd, input logic wr,
                           input logic [1:0] width, input logic uns, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rdi,
                           input logic regw, input logic m2r);
        int          sz, o;
        logic        mis;
        logic [5:0]  idx;
        logic [31:0] w, val;
        logic [1:0]  off;
        wb_t         e, got;
        sz  = (width == 2'b00) ? 0 : (width == 2'b01) ? 1 : 2;
        idx = addr[7:2];
        w   = mdl_mem[idx];
`ifdef MEM_MISALIGN_CHECK_EN
        off = addr[1:0];
        mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
`else
        off = (sz == 0) ? addr[1:0] : (sz == 1) ? {addr[1], 1'b0} : 2'b00;
        mis = 1'b0;
`endif
        o = int'(off);
        case (sz)
            0:       val = uns ? {24'h0, w[o*8 +: 8]} : {{24{w[o*8+7]}}, w[o*8 +: 8]};
            1:       val = uns ? {16'h0, w[o*8 +: 16]} : {{16{w[o*8+15]}}, w[o*8 +: 16]};
            default: val = w;
        endcase
        if (!rd || mis) val = 32'h0;
        if (step) begin
            if ((rd || wr) && mis) exp_mis = 1'b1;
            exp_wb.mem_data = val; exp_wb.alu = addr; exp_wb.rd = rdi;
            exp_wb.rw = regw; exp_wb.m2r = m2r; exp_wb.mis = exp_mis;
            if (wr && !mis) begin
                case (sz)
                    0:       w[o*8 +: 8]  = data[7:0];
                    1:       w[o*8 +: 16] = data[15:0];
                    default: w = data;
                endcase
                mdl_mem[idx] = w;
            end
        end
        sb_q.push_back(exp_wb);
        bus.i_step = step; bus.i_mem_read = rd; bus.i_mem_write = wr; bus.i_width = width;
        bus.i_unsigned = uns; bus.i_alu_result = addr; bus.i_store_data = data;
        bus.i_rd = rdi; bus.i_reg_write = regw; bus.i_mem_to_reg = m2r;
        @(posedge i_clk); #1;
        got = actual_wb();
        e   = sb_q.pop_front();
        checks++;
        if (got !== e)
            $display("FAIL pipe[%s] addr=%h got=%h expected=%h", tag, addr, got, e);
        else begin
            passed++;
            $display("ok   pipe[%s] addr=%h wb_data=%h", tag, addr, got.mem_data);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (actual_wb() !== '0) $display("FAIL reset_wb got=%h expected=0", actual_wb());
        else passed++;
        checks++;
        if ({bus.o_dbg_valid, bus.o_dbg_busy, bus.o_dbg_done} !== 3'b000)
            $display("FAIL reset_dbg got=%b expected=000", {bus.o_dbg_valid, bus.o_dbg_busy, bus.o_dbg_done});
        else passed++;
        i_reset = 1'b0;
        exp_wb = '0; exp_mis = 1'b0;
        $display("reset done");
    endtask

    task automatic test_fill();
        for (int i = 0; i < MW; i++)
            pipe_op("fill", 1, 0, 1, WIDTH_WORD, 0, 32'(i * 4), fill_pat(i), 5'(i), 1, 0);
    endtask

    task automatic test_word();
        pipe_op("sw", 1, 0, 1, WIDTH_WORD, 0, 32'h8, 32'hDEADBEEF, 5'd1, 0, 0);
        pipe_op("lw", 1, 1, 0, WIDTH_WORD, 0, 32'h8, 32'h0, 5'd2, 1, 1);
        checks++;
        if (bus.o_wb_mem_data !== 32'hDEADBEEF) $display("FAIL lw_const got=%h expected=deadbeef", bus.o_wb_mem_data);
        else passed++;
    endtask

    task automatic test_byte();
        pipe_op("sb", 1, 0, 1, WIDTH_BYTE, 0, 32'h5, 32'h12345680, 5'd3, 0, 0);
        pipe_op("lb", 1, 1, 0, WIDTH_BYTE, 0, 32'h5, 32'h0, 5'd4, 1, 1);
        checks++;
        if (bus.o_wb_mem_data !== 32'hFFFFFF80) $display("FAIL lb_const got=%h expected=ffffff80", bus.o_wb_mem_data);
        else passed++;
        pipe_op("lbu", 1, 1, 0, WIDTH_BYTE, 1, 32'h5, 32'h0, 5'd5, 1, 1);
        checks++;
        if (bus.o_wb_mem_data !== 32'h00000080) $display("FAIL lbu_const got=%h expected=00000080", bus.o_wb_mem_data);
        else passed++;
        pipe_op("lw4", 1, 1, 0, WIDTH_WORD, 0, 32'h4, 32'h0, 5'd6, 1, 1);
        checks++;
        if (bus.o_wb_mem_data !== 32'h01FE805B) $display("FAIL lane1_only got=%h expected=01fe805b", bus.o_wb_mem_data);
        else passed++;
    endtask

    task automatic test_half();
        pipe_op("sh", 1, 0, 1, WIDTH_HALF, 0, 32'h2, 32'hABCD1234, 5'd7, 0, 0);
        pipe_op("lhu", 1, 1, 0, WIDTH_HALF, 1, 32'h2, 32'h0, 5'd8, 1, 1);
        checks++;
        if (bus.o_wb_mem_data !== 32'h00001234) $display("FAIL lhu_const got=%h expected=00001234", bus.o_wb_mem_data);
        else passed++;
        pipe_op("lw_mis", 1, 1, 0, WIDTH_WORD, 0, 32'h2, 32'h0, 5'd9, 1, 1);
        pipe_op("sw_mis", 1, 0, 1, WIDTH_WORD, 0, 32'h2, 32'hCAFEF00D, 5'd10, 0, 0);
        pipe_op("lw0", 1, 1, 0, WIDTH_WORD, 0, 32'h0, 32'h0, 5'd11, 1, 1);
        checks++;
`ifdef MEM_MISALIGN_CHECK_EN
        if (bus.o_wb_mem_data !== 32'h1234005A || bus.o_misaligned !== 1'b1)
            $display("FAIL mis_suppress got=%h/%b expected=1234005a/1", bus.o_wb_mem_data, bus.o_misaligned);
        else passed++;
`else
        if (bus.o_wb_mem_data !== 32'hCAFEF00D || bus.o_misaligned !== 1'b0)
            $display("FAIL forced_align got=%h/%b expected=cafef00d/0", bus.o_wb_mem_data, bus.o_misaligned);
        else passed++;
`endif
    endtask

    task automatic test_stall();
        pipe_op("stall", 0, 0, 1, WIDTH_WORD, 0, 32'h8, 32'h11111111, 5'd12, 1, 1);
        pipe_op("lw_after_stall", 1, 1, 0, WIDTH_WORD, 0, 32'h8, 32'h0, 5'd13, 1, 1);
        checks++;
        if (bus.o_wb_mem_data !== 32'hDEADBEEF) $display("FAIL stall_nowrite got=%h expected=deadbeef", bus.o_wb_mem_data);
        else passed++;
    endtask

    task automatic test_wrap();
        pipe_op("sw_wrap", 1, 0, 1, WIDTH_WORD, 0, 32'h10C, 32'h5A5A0001, 5'd14, 0, 0);
        pipe_op("lw_wrap", 1, 1, 0, WIDTH_WORD, 0, 32'hC, 32'h0, 5'd15, 1, 1);
        checks++;
        if (bus.o_wb_mem_data !== 32'h5A5A0001) $display("FAIL wrap got=%h expected=5a5a0001", bus.o_wb_mem_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            pipe_op("rand", ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_dump();
        int          cyc = 0, words = 0, done_cnt = 0;
        logic        rdy, hs, prev_stall = 1'b0;
        logic [31:0] prev_data = 32'h0, held_alu;
        // start coincident with a store: store lands, dump begins next cycle
        bus.i_dbg_start = 1'b1;
        pipe_op("sw_start", 1, 0, 1, WIDTH_WORD, 0, 32'h20, 32'h0BADF00D, 5'd16, 0, 0);
        bus.i_dbg_start = 1'b0;
        checks++;
        if ({bus.o_dbg_valid, bus.o_dbg_busy} !== 2'b11)
            $display("FAIL dump_first_valid got=%b expected=11", {bus.o_dbg_valid, bus.o_dbg_busy});
        else passed++;
        for (int i = 0; i < MW; i++) dump_q.push_back(mdl_mem[i]);
        held_alu = exp_wb.alu;
        // pipeline keeps requesting a store; it must be ignored while busy
        bus.i_step = 1; bus.i_mem_write = 1; bus.i_mem_read = 1; bus.i_width = WIDTH_WORD;
        bus.i_alu_result = 32'hF8; bus.i_store_data = 32'hFFFF0000;
        while (words < MW && cyc < 400) begin
            if (bus.o_dbg_valid) begin
                checks++;
                if (bus.o_dbg_data !== dump_q[0])
                    $display("FAIL dump_word[%0d] got=%h expected=%h", words, bus.o_dbg_data, dump_q[0]);
                else passed++;
                if (prev_stall) begin
                    checks++;
                    if (bus.o_dbg_data !== prev_data)
                        $display("FAIL dump_stable[%0d] got=%h expected=%h", words, bus.o_dbg_data, prev_data);
                    else passed++;
                end
            end
            checks++;
            if (bus.o_wb_alu_result !== held_alu)
                $display("FAIL dump_step_ignored got=%h expected=%h", bus.o_wb_alu_result, held_alu);
            else passed++;
            rdy = (cyc % 2 == 1);
            bus.i_dbg_ready = rdy;
            hs = bus.o_dbg_valid && rdy;
            prev_stall = bus.o_dbg_valid && !rdy;
            prev_data = bus.o_dbg_data;
            @(posedge i_clk); #1;
            if (hs) begin
                $display("dump word %0d = %h", words, dump_q[0]);
                void'(dump_q.pop_front());
                words++;
            end
            if (bus.o_dbg_done) done_cnt++;
            cyc++;
        end
        checks++;
        if (words != MW) $display("FAIL dump_timeout words=%0d expected=%0d", words, MW);
        else passed++;
        checks++;
        if ({bus.o_dbg_done, bus.o_dbg_valid, bus.o_dbg_busy} !== 3'b100)
            $display("FAIL dump_end got=%b expected=100", {bus.o_dbg_done, bus.o_dbg_valid, bus.o_dbg_busy});
        else passed++;
        idle_inputs();
        @(posedge i_clk); #1;
        if (bus.o_dbg_done) done_cnt++;
        checks++;
        if (done_cnt != 1) $display("FAIL done_pulse count=%0d expected=1", done_cnt);
        else passed++;
        dump_q.delete();
        pipe_op("lw_after_dump", 1, 1, 0, WIDTH_WORD, 0, 32'hF8, 32'h0, 5'd17, 1, 1);
    endtask

    task automatic test_reset_mid_dump();
        int edges;
        idle_inputs();
        bus.i_dbg_start = 1'b1;
        @(posedge i_clk); #1;
        bus.i_dbg_start = 1'b0;
        bus.i_dbg_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.o_dbg_valid !== 1'b1 || bus.o_dbg_data !== mdl_mem[k])
                $display("FAIL pre_reset_word[%0d] got=%b/%h expected=1/%h", k, bus.o_dbg_valid, bus.o_dbg_data, mdl_mem[k]);
            else passed++;
            @(posedge i_clk); #1;
        end
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if ({bus.o_dbg_valid, bus.o_dbg_busy, bus.o_dbg_done} !== 3'b000)
            $display("FAIL async_drop got=%b expected=000", {bus.o_dbg_valid, bus.o_dbg_busy, bus.o_dbg_done});
        else passed++;
        exp_wb = '0; exp_mis = 1'b0;
        checks++;
        if (actual_wb() !== exp_wb) $display("FAIL reset_wb_mid got=%h expected=0", actual_wb());
        else passed++;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        bus.i_dbg_ready = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (bus.o_dbg_done !== 1'b0) $display("FAIL no_done_after_reset got=%b expected=0", bus.o_dbg_done);
        else passed++;
        $display("reset mid-dump applied");
        bus.i_dbg_start = 1'b1;
        @(posedge i_clk); #1;
        bus.i_dbg_start = 1'b0;
        bus.i_dbg_ready = 1'b1;
        edges = 1;
        for (int k = 0; k < MW; k++) begin
            checks++;
            if (bus.o_dbg_valid !== 1'b1 || bus.o_dbg_data !== mdl_mem[k] || bus.o_dbg_done !== 1'b0)
                $display("FAIL restart_word[%0d] got=%b/%h expected=1/%h", k, bus.o_dbg_valid, bus.o_dbg_data, mdl_mem[k]);
            else passed++;
            @(posedge i_clk); #1;
            edges++;
        end
        checks++;
        if (edges != MW + 1 || {bus.o_dbg_done, bus.o_dbg_valid} !== 2'b10)
            $display("FAIL dump_length edges=%0d done/valid=%b expected=%0d/10", edges, {bus.o_dbg_done, bus.o_dbg_valid}, MW + 1);
        else passed++;
        bus.i_dbg_ready = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (bus.o_dbg_done !== 1'b0) $display("FAIL done_single got=%b expected=0", bus.o_dbg_done);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_wb = '0; exp_mis = 1'b0;
        test_reset();
        test_fill();
        test_word();
        test_byte();
        test_half();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_dump();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
